// File: rtl/pmod_in_pkg.sv
// Shared constants for the I2S ADC capture block: counter bit positions,
// sample phase, default sample width and FSM encoding.
package pmod_in_pkg;

    localparam int CNT_W        = 11;
    localparam int MCLK_BIT     = 1;
    localparam int SCLK_BIT     = 4;
    localparam int LR_BIT       = 10;
    localparam int SAMPLE_W_DEF = 16;

    // Three clocks after the sclk rise, so the synchronized bit is settled.
    localparam logic [4:0] SAMPLE_PHASE = 5'b10011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing generator: owns the 11-bit frame counter, the registered
// mclk/sclk/lrclk outputs, and exports the sample strobe and slot index.
module i2s_clkgen
    import pmod_in_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       mclk,
    output logic       sclk,
    output logic       lrclk,
    output logic       sample_stb,
    output logic [4:0] slot,
    output logic       right_ch,
    output logic       wrap
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mclk_q, sclk_q, lrclk_q;

    always_comb begin
        cnt_d = run ? cnt_q + CNT_W'(1) : '0;
    end

    // Clocks are registered from the next count so they line up with cnt_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            mclk_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            mclk_q  <= cnt_d[MCLK_BIT];
            sclk_q  <= cnt_d[SCLK_BIT];
            lrclk_q <= cnt_d[LR_BIT];
        end
    end

    assign mclk       = mclk_q;
    assign sclk       = sclk_q;
    assign lrclk      = lrclk_q;
    assign sample_stb = run && (cnt_q[4:0] == SAMPLE_PHASE);
    assign slot       = cnt_q[9:5];
    assign right_ch   = cnt_q[LR_BIT];
    assign wrap       = run && (cnt_q == '1);

endmodule

// File: rtl/pmod_in.sv
// I2S stereo ADC capture: run/prime FSM, serial shift-in, stereo pair
// handoff with valid/ready handshake and sticky overrun.
module pmod_in
    import pmod_in_pkg::*;
#(
    parameter int SAMPLE_W = pmod_in_pkg::SAMPLE_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sdout,
    output logic                mclk,
    output logic                sclk,
    output logic                lrclk,
    output logic [SAMPLE_W-1:0] left,
    output logic [SAMPLE_W-1:0] right,
    output logic                valid,
    input  logic                ready,
    output logic                overrun
);

    localparam logic [4:0] LAST_SLOT = 5'(SAMPLE_W);

    logic [1:0]          state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [SAMPLE_W-1:0] shift_q, shift_d, hold_q, hold_d;
    logic [SAMPLE_W-1:0] left_q, left_d, right_q, right_d;
    logic                valid_q, valid_d, overrun_q, overrun_d;
    logic                sample_stb, right_ch, wrap;
    logic [4:0]          slot;
    logic                data_slot, last_slot, load;

    i2s_clkgen u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .run       (state_q != ST_IDLE),
        .mclk      (mclk),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .sample_stb(sample_stb),
        .slot      (slot),
        .right_ch  (right_ch),
        .wrap      (wrap)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (en) state_d = ST_PRIME;
            ST_PRIME: if (wrap) state_d = en ? ST_RUN : ST_IDLE;
            ST_RUN:   if (wrap && !en) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        sync_d = {sync_q[0], sdout};

        // Slot 0 carries the I2S one-bit delay; only slots 1..SAMPLE_W hold data.
        data_slot = sample_stb && (slot != 5'd0) && (slot <= LAST_SLOT);
        last_slot = sample_stb && (slot == LAST_SLOT);
        load      = last_slot && right_ch && (state_q == ST_RUN);

        shift_d = data_slot ? ((shift_q << 1) | SAMPLE_W'(sync_q[1])) : shift_q;
        hold_d  = (last_slot && !right_ch) ? shift_d : hold_q;

        left_d    = left_q;
        right_d   = right_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready) valid_d = 1'b0;
        // A load wins over a same-cycle consume; only an unconsumed pair is an overrun.
        if (load) begin
            left_d  = hold_q;
            right_d = shift_d;
            valid_d = 1'b1;
            if (valid_q && !ready) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            shift_q   <= '0;
            hold_q    <= '0;
            left_q    <= '0;
            right_q   <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            left_q    <= left_d;
            right_q   <= right_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign left    = left_q;
    assign right   = right_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pmod_in.sv
// Bench for pmod_in: frame-timing reference model driving an I2S ADC,
// scoreboard of expected stereo pairs, and a per-cycle monitor.
module tb_pmod_in;

    localparam int W        = 16;
    localparam int FRAME    = 2048;
    localparam int LOAD_POS = 1024 + 32 * W + 19;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         ready = 1'b1;
    logic         sdout = 1'b0;
    logic         mclk, sclk, lrclk, valid, overrun;
    logic [W-1:0] left, right;

    // reference model state
    bit           m_active;
    logic [10:0]  m_pos = '0;
    int           m_frame;
    bit           fixed_mode = 1'b1;
    logic [W-1:0] cur_l = '0, cur_r = '0;
    pair_t        exp_q[$];
    bit           exp_ovr;

    int n_cmp = 0;
    int n_bad = 0;

    pmod_in #(.SAMPLE_W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sdout  (sdout),
        .mclk   (mclk),
        .sclk   (sclk),
        .lrclk  (lrclk),
        .left   (left),
        .right  (right),
        .valid  (valid),
        .ready  (ready),
        .overrun(overrun)
    );

    initial forever #5 clk = ~clk;

    // Reference: position inside the frame is simply cycles since capture
    // start modulo 2048; frame 0 after enable is discarded, later frames
    // deliver their pair once the last right-channel bit has been sampled.
    initial forever begin
        pair_t p;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_active = 1'b0;
            m_pos    = '0;
            m_frame  = 0;
            exp_ovr  = 1'b0;
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && ready) void'(exp_q.pop_front());
            if (!m_active) begin
                if (en) begin
                    m_active = 1'b1;
                    m_pos    = '0;
                    m_frame  = 0;
                    cur_l    = fixed_mode ? W'(16'h8001) : W'($urandom);
                    cur_r    = fixed_mode ? W'(16'h7FFE) : W'($urandom);
                end
            end else begin
                if (m_frame >= 1 && int'(m_pos) == LOAD_POS) begin
                    if (exp_q.size() != 0) begin
                        void'(exp_q.pop_front());
                        exp_ovr = 1'b1;
                    end
                    p.l = cur_l;
                    p.r = cur_r;
                    exp_q.push_back(p);
                end
                if (int'(m_pos) == FRAME - 1) begin
                    m_pos = '0;
                    if (en) begin
                        m_frame++;
                        cur_l = fixed_mode ? W'(16'h8001) : W'($urandom);
                        cur_r = fixed_mode ? W'(16'h7FFE) : W'($urandom);
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_pos = m_pos + 11'd1;
                end
            end
        end
    end

    // ADC: one bit per 32-clock slot, MSB in slot 1, slot 0 junk, tail slots 1.
    initial forever begin
        int           s;
        logic [W-1:0] word;
        @(negedge clk);
        s    = int'(m_pos[9:5]);
        word = m_pos[10] ? cur_r : cur_l;
        if (s == 0)      sdout = 1'($urandom);
        else if (s <= W) sdout = word[W - s];
        else             sdout = 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: clocks, valid and overrun every cycle; data whenever a pair is taken.
    initial forever begin
        @(negedge clk or posedge rst);
        if (rst) #1;
        check("mclk",    32'(mclk),    32'(m_pos[1]));
        check("sclk",    32'(sclk),    32'(m_pos[4]));
        check("lrclk",   32'(lrclk),   32'(m_pos[10]));
        check("valid",   32'(valid),   32'(exp_q.size() != 0));
        check("overrun", 32'(overrun), 32'(exp_ovr));
        if (rst) begin
            check("left_rst",  32'(left),  32'd0);
            check("right_rst", 32'(right), 32'd0);
        end else if (valid && ready && exp_q.size() != 0) begin
            check("left",  32'(left),  32'(exp_q[0].l));
            check("right", 32'(right), 32'(exp_q[0].r));
        end
    end

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (int'(m_pos) != p && n < 3 * FRAME);
    endtask

    initial begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);

        // fixed words, ready high: first pair at the end of the second frame
        #1 en = 1'b1;
        repeat (3 * FRAME) @(posedge clk);
        #1 fixed_mode = 1'b0;

        // one pair left pending, next load coincides with a single-cycle ready
        wait_pos(0);
        ready = 1'b0;
        wait_pos(LOAD_POS);
        wait_pos(0);
        wait_pos(LOAD_POS);
        ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;

        // two further loads with nobody consuming -> sticky overrun
        wait_pos(LOAD_POS);
        wait_pos(0);
        wait_pos(LOAD_POS);
        wait_pos(100);
        ready = 1'b1;
        repeat (200) @(posedge clk);

        // random back-pressure
        for (int i = 0; i < 5 * FRAME; i++) begin
            @(posedge clk);
            #1 ready = ($urandom % 4) != 0;
        end

        // stop mid-frame: this frame still delivers, then idle
        ready = 1'b1;
        wait_pos(600);
        en = 1'b0;
        repeat (3 * FRAME) @(posedge clk);

        // restart, reset mid-frame in RUN, restart again through PRIME
        #1 en = 1'b1;
        wait_pos(1500);
        wait_pos(1500);
        wait_pos(1500);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3 * FRAME + 200) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
